// File: rtl/mult_lp_pkg.sv
// Shared configuration, stage record and helpers for the mult_lp_v2 shift-add multiplier.
// The stage record is sized from the package configuration; the top checks that its parameters agree.
package mult_lp_pkg;

  localparam int unsigned MULT_W  = 16;
  localparam int unsigned MULT_K  = 2;
  localparam int unsigned MULT_TW = 4;

  typedef struct packed {
    logic                  vld;
    logic                  sgn;
    logic                  neg;
    logic [MULT_TW-1:0]    tag;
    logic [MULT_W-1:0]     a;
    logic [MULT_W-1:0]     b;
    logic [2*MULT_W-1:0]   sum;
  } stage_t;

  function automatic int unsigned latency(input int unsigned w, input int unsigned k);
    return (w / k) + 32'd1;
  endfunction

  // The most negative value maps to 2^(W-1), which still fits as an unsigned W-bit magnitude.
  function automatic logic [MULT_W-1:0] magnitude(input logic [MULT_W-1:0] v, input logic is_signed);
    logic [MULT_W-1:0] m;
    if (is_signed && v[MULT_W-1]) begin
      m = ~v + {{(MULT_W-1){1'b0}}, 1'b1};
    end else begin
      m = v;
    end
    return m;
  endfunction

endpackage

// File: rtl/mult_lp_v2_if.sv
// Operand/result handshake bundle for mult_lp_v2.
interface mult_lp_v2_if #(
  parameter int unsigned W  = 16,
  parameter int unsigned TW = 4
);
  logic              in_valid;
  logic              in_ready;
  logic              in_signed;
  logic [W-1:0]      dA;
  logic [W-1:0]      dB;
  logic [TW-1:0]     in_tag;
  logic              out_valid;
  logic              out_ready;
  logic [2*W-1:0]    a_mult_b;
  logic [TW-1:0]     out_tag;

  modport master (
    output in_valid, in_signed, dA, dB, in_tag, out_ready,
    input  in_ready, out_valid, a_mult_b, out_tag
  );

  modport slave (
    input  in_valid, in_signed, dA, dB, in_tag, out_ready,
    output in_ready, out_valid, a_mult_b, out_tag
  );
endinterface

// File: rtl/mult_lp_stage.sv
// One shift-add stage: folds the K-bit multiplier digit selected by IDX (MSB digit first) into the partial sum.
module mult_lp_stage
  import mult_lp_pkg::*;
#(
  parameter int unsigned IDX = 0
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   stall,
  input  stage_t prev,
  output stage_t cur
);

  localparam int unsigned W   = MULT_W;
  localparam int unsigned K   = MULT_K;
  localparam int unsigned MSB = W - 1 - IDX * K;

  logic [K-1:0]   digit;
  logic [2*W-1:0] partial;
  stage_t         cur_d;
  stage_t         cur_q;

  always_comb begin
    cur_d   = cur_q;
    digit   = prev.b[MSB -: K];
    partial = {{W{1'b0}}, prev.a} * {{(2*W-K){1'b0}}, digit};
    if (!stall) begin
      cur_d     = prev;
      cur_d.sum = (prev.sum << K) + partial;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur_q.vld <= 1'b0;
    end else begin
      cur_q <= cur_d;
    end
  end

  assign cur = cur_q;

endmodule

// File: rtl/mult_lp_v2.sv
// Fully pipelined signed/unsigned multiplier: input register, W/K shift-add stages, output register,
// with a single global stall driven by output backpressure.
module mult_lp_v2
  import mult_lp_pkg::*;
#(
  parameter int unsigned W  = MULT_W,
  parameter int unsigned K  = MULT_K,
  parameter int unsigned TW = MULT_TW
) (
  input logic           clk,
  input logic           rst_n,
  mult_lp_v2_if.slave   bus
);

  localparam int unsigned S = latency(W, K) - 32'd1;

  if (W % K != 0) begin : g_bad_k
    $error("mult_lp_v2: K (%0d) must divide W (%0d)", K, W);
  end
  if (W != MULT_W || K != MULT_K || TW != MULT_TW) begin : g_bad_cfg
    $error("mult_lp_v2: parameters must match the mult_lp_pkg stage record configuration");
  end

  logic           stall;
  stage_t         in_d;
  stage_t         in_q;
  stage_t         chain [0:S];
  logic           out_valid_d;
  logic           out_valid_q;
  logic [2*W-1:0] a_mult_b_d;
  logic [2*W-1:0] a_mult_b_q;
  logic [TW-1:0]  out_tag_d;
  logic [TW-1:0]  out_tag_q;

  assign stall        = out_valid_q && !bus.out_ready;
  assign bus.in_ready = !stall;

  always_comb begin
    in_d = in_q;
    if (!stall) begin
      in_d.vld = bus.in_valid;
      in_d.sgn = bus.in_signed;
      in_d.neg = bus.in_signed & (bus.dA[W-1] ^ bus.dB[W-1]);
      in_d.tag = bus.in_tag;
      in_d.a   = magnitude(bus.dA, bus.in_signed);
      in_d.b   = magnitude(bus.dB, bus.in_signed);
      in_d.sum = '0;
    end
  end

  assign chain[0] = in_q;

  for (genvar i = 0; i < S; i++) begin : g_stage
    mult_lp_stage #(.IDX(i)) u_stage (
      .clk   (clk),
      .rst_n (rst_n),
      .stall (stall),
      .prev  (chain[i]),
      .cur   (chain[i+1])
    );
  end

  // The last stage carries a magnitude product; the sign is applied here on the way out.
  always_comb begin
    out_valid_d = out_valid_q;
    a_mult_b_d  = a_mult_b_q;
    out_tag_d   = out_tag_q;
    if (!stall) begin
      out_valid_d = chain[S].vld;
      if (chain[S].vld) begin
        a_mult_b_d = chain[S].neg ? (~chain[S].sum + {{(2*W-1){1'b0}}, 1'b1}) : chain[S].sum;
        out_tag_d  = chain[S].tag;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      in_q.vld    <= 1'b0;
      out_valid_q <= 1'b0;
      a_mult_b_q  <= '0;
      out_tag_q   <= '0;
    end else begin
      in_q        <= in_d;
      out_valid_q <= out_valid_d;
      a_mult_b_q  <= a_mult_b_d;
      out_tag_q   <= out_tag_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.a_mult_b  = a_mult_b_q;
  assign bus.out_tag   = out_tag_q;

endmodule

// File: tb/tb_mult_lp_v2.sv
// Self-checking bench for mult_lp_v2 (W=16, K=2, TW=4): vector table, directed stall/reset
// sequences and a long randomized handshake run, all checked through an in-order scoreboard.
module tb_mult_lp_v2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mult_lp_v2_if #(.W(16), .TW(4)) bus ();

  mult_lp_v2 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] prod;
    logic [3:0]  tag;
    int          acc;
  } exp_t;

  typedef struct {
    logic        s;
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  tag;
    logic [31:0] prod;
  } vec_t;

  exp_t        sb [$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  logic        check_lat = 1'b0;
  logic        stalled_prev = 1'b0;
  logic [31:0] hold_p;
  logic [3:0]  hold_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] ref_mult(input logic s, input logic [15:0] a, input logic [15:0] b);
    longint sa;
    longint sb_v;
    longint p;
    sa   = s ? longint'($signed(a)) : longint'({48'd0, a});
    sb_v = s ? longint'($signed(b)) : longint'({48'd0, b});
    p    = sa * sb_v;
    return p[31:0];
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: handshake invariant, hold stability and in-order result checking.
  always @(negedge clk) begin
    if (rst_n !== 1'b1) begin
      sb.delete();
      stalled_prev = 1'b0;
    end else begin
      chk("in_ready_rule", {63'd0, bus.in_ready}, {63'd0, !(bus.out_valid && !bus.out_ready)});
      if (stalled_prev && bus.out_valid) begin
        chk("hold_product", {32'd0, bus.a_mult_b}, {32'd0, hold_p});
        chk("hold_tag", {60'd0, bus.out_tag}, {60'd0, hold_t});
      end
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_result", {32'd0, bus.a_mult_b}, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("product", {32'd0, bus.a_mult_b}, {32'd0, e.prod});
          chk("tag", {60'd0, bus.out_tag}, {60'd0, e.tag});
          if (check_lat) chk("latency", 64'(cyc - e.acc), 64'd9);
        end
      end
      stalled_prev = bus.out_valid && !bus.out_ready;
      hold_p = bus.a_mult_b;
      hold_t = bus.out_tag;
    end
  end

  task automatic send(input logic s, input logic [15:0] a, input logic [15:0] b,
                      input logic [3:0] t, input logic [31:0] e);
    logic accepted;
    accepted      = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_signed = s;
    bus.dA        = a;
    bus.dB        = b;
    bus.in_tag    = t;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        sb.push_back('{prod: e, tag: t, acc: cyc + 1});
        accepted = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (!accepted) chk("send_timeout", {63'd0, accepted}, 64'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic send_rand();
    logic        s;
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  t;
    s = 1'($urandom_range(0, 1));
    a = 16'($urandom);
    b = 16'($urandom);
    t = 4'($urandom);
    send(s, a, b, t, ref_mult(s, a, b));
  endtask

  task automatic drain();
    bus.out_ready = 1'b1;
    for (int k = 0; k < 200 && sb.size() != 0; k++) begin
      @(posedge clk);
      #1;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  vec_t vecs [10];
  logic done;

  initial begin
    vecs[0] = '{1'b0, 16'h0003, 16'h0005, 4'h1, 32'h0000_000F};
    vecs[1] = '{1'b0, 16'hFFFF, 16'hFFFF, 4'h2, 32'hFFFE_0001};
    vecs[2] = '{1'b1, 16'hFFFD, 16'h0005, 4'h3, 32'hFFFF_FFF1};
    vecs[3] = '{1'b1, 16'h8000, 16'h8000, 4'h4, 32'h4000_0000};
    vecs[4] = '{1'b1, 16'h8000, 16'h0001, 4'h5, 32'hFFFF_8000};
    vecs[5] = '{1'b1, 16'h7FFF, 16'h8000, 4'h6, 32'hC000_8000};
    vecs[6] = '{1'b0, 16'h0000, 16'h1234, 4'h7, 32'h0000_0000};
    vecs[7] = '{1'b1, 16'hFFFF, 16'hFFFF, 4'h8, 32'h0000_0001};
    vecs[8] = '{1'b0, 16'h8000, 16'h8000, 4'h9, 32'h4000_0000};
    vecs[9] = '{1'b0, 16'h1234, 16'h5678, 4'hA, 32'h0626_0060};

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_signed = 1'b0;
    bus.dA        = 16'h0000;
    bus.dB        = 16'h0000;
    bus.in_tag    = 4'h0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("reset_product", {32'd0, bus.a_mult_b}, 64'd0);
    chk("reset_tag", {60'd0, bus.out_tag}, 64'd0);
    chk("reset_in_ready", {63'd0, bus.in_ready}, 64'd1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Vector table, back-to-back with an always-ready sink.
    check_lat = 1'b1;
    for (int i = 0; i < 10; i++) send(vecs[i].s, vecs[i].a, vecs[i].b, vecs[i].tag, vecs[i].prod);
    drain();

    // Back-to-back random mixed-mode stream.
    for (int i = 0; i < 20; i++) send_rand();
    drain();

    // Five-cycle backpressure with a full pipe.
    check_lat = 1'b0;
    fork
      begin
        for (int i = 0; i < 20; i++) send_rand();
      end
      begin
        repeat (12) @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        repeat (5) begin
          @(negedge clk);
          chk("stall_in_ready", {63'd0, bus.in_ready}, 64'd0);
          chk("stall_out_valid", {63'd0, bus.out_valid}, 64'd1);
          @(posedge clk);
        end
        #1;
        bus.out_ready = 1'b1;
      end
    join
    drain();

    // Reset with four operations in flight.
    for (int i = 0; i < 4; i++) send_rand();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("flush_out_valid", {63'd0, bus.out_valid}, 64'd0);
    end
    @(posedge clk);
    #1;
    check_lat = 1'b1;
    send(1'b0, 16'h0003, 16'h0005, 4'h1, 32'h0000_000F);
    drain();

    // Long run with random input gaps and random backpressure.
    check_lat = 1'b0;
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 10000; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
          end
          send_rand();
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          bus.out_ready = 1'($urandom_range(0, 1));
          @(posedge clk);
          #1;
        end
      end
    join
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
